piece_ctrl: RTL and testbench
=============================

// Module: piece_ctrl
// PURPOSE
//  Upstream feeder of the block-shape lookup: owns the falling piece's identity and rotation.
//  Draws pieces from a free-running LFSR, keeps a one-deep next-piece preview, and drives
//  block_num/rotate_tmp into the lookup. Runs a fit-check handshake with the collision stage
//  on every spawn and rotate, then commits or reverts the rotation.
// PARAMETERS
//  NUM_PIECES   5      legal piece indices 0..NUM_PIECES-1
//  LFSR_SEED    8'hA5  LFSR reset value; 0 is forced to 8'h01
//  FIT_TIMEOUT  15     cycles to wait for fit_valid before treating the check as a fail
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  rst          in   1   asynchronous, active-high reset
//  spawn_req    in   1   pulse: bring the preview piece into play
//  rot_req      in   1   pulse: rotate the active piece
//  rot_dir      in   1   0 = clockwise (+1), 1 = counter-clockwise (-1)
//  lock         in   1   pulse: active piece has landed; release it
//  fit_valid    in   1   collision stage result strobe
//  fit_ok       in   1   result qualifier, 1 = candidate fits (sampled only with fit_valid)
//  block_num    out  10  piece index to lookup, zero-extended
//  rotate_tmp   out  10  rotation to lookup (candidate during a check), zero-extended, 0..3
//  next_num     out  3   preview piece index
//  fit_req      out  1   high while a fit check is outstanding
//  piece_active out  1   a piece is in play
//  rot_done     out  1   1-cycle pulse: rotation committed
//  game_over    out  1   sticky until rst
// BEHAVIOUR
//  Reset: all outputs 0, lfsr=LFSR_SEED, state IDLE, committed rot=0, timeout counter=0.
//  LFSR: 8-bit Fibonacci, taps 8,6,5,4; advances every cycle in every state.
//  Draw: v=lfsr[2:0]; idx = (v>=NUM_PIECES) ? v-NUM_PIECES : v. Sampled at the SPAWN edge.
//  States:
//   IDLE    : spawn_req -> SPAWN. rot_req and lock are ignored.
//   SPAWN   : 1 cycle. block_num<=next_num, next_num<=draw, rot<=0, fit_req<=1 -> SPAWN_CHK.
//   SPAWN_CHK: fit_valid&fit_ok -> ACTIVE with piece_active=1.
//            fit_valid&!fit_ok, or timeout -> OVER with game_over=1.
//   ACTIVE  : lock -> IDLE with piece_active=0. Otherwise rot_req -> ROT_CHK with
//            cand=(rot+1)&3 (cw) or (rot+3)&3 (ccw) and fit_req=1.
//            lock beats a simultaneous rot_req. spawn_req is ignored.
//   ROT_CHK : rotate_tmp shows cand. fit_valid&fit_ok -> rot<=cand, rot_done pulse.
//            fit_valid&!fit_ok, or timeout -> keep rot. Both go to ACTIVE.
//            rot_req is dropped (not queued). lock here -> abort check, IDLE.
//   OVER    : terminal; only rst exits.
//  fit_req falls in the cycle after fit_valid is accepted, or on timeout.
//  fit_valid outside a CHK state is ignored.
//  Latency: rot_req -> fit_req is 1 cycle; fit_valid -> rot_done/rotate_tmp update is 1 cycle.
//  Timeout counter clears on entering a CHK state. Fail fires when it reaches FIT_TIMEOUT.
//  rotate_tmp outside ROT_CHK = committed rot; it wraps 3->0 (cw) and 0->3 (ccw).
//  rst mid-check: immediate return to reset values; a pending fit_valid is lost.
// STRUCTURE
//  Shared defines header holds NUM_PIECES, NUM_ROT=4, the state encodings, and the
//  10-bit index width that the shape lookup also uses.
//  Sub-module piece_lfsr: LFSR plus the draw fold. Outputs a 3-bit idx; clk/rst only.
//  Top holds the FSM, rotation registers, timeout counter and output muxing.
// TESTING
//  1 rst, then spawn_req with fit_ok=1 on cycle 2 -> block_num = reset next_num (0),
//    next_num = draw, rotate_tmp=0, piece_active=1.
//  2 ACTIVE rot=3, rot_req cw, fit_ok=1 -> rotate_tmp shows 0 during check, rot_done pulse,
//    committed rot=0. Repeat ccw from 0 with ok -> 3.
//  3 rot_req, then fit_valid with fit_ok=0 -> rotate_tmp returns to the old value, no rot_done.
//  4 rot_req with fit_valid held 0 for FIT_TIMEOUT=15 cycles -> fit_req drops, rot unchanged.
//  5 lock and rot_req in the same cycle -> IDLE, no fit_req. Spawn fit_ok=0 -> game_over
//    sticks and spawn_req is ignored until rst.
//  6 10k spawns, SEED=8'hA5 -> every block_num < 5, all of 0..4 appear, matches the
//    reference LFSR sequence.

Source files
------------

// File: rtl/piece_ctrl_pkg.sv
// Shared constants for the falling-piece controller and the block-shape lookup it feeds.
package piece_ctrl_pkg;

  localparam int unsigned NUM_PIECES_DFLT  = 5;
  localparam int unsigned NUM_ROT          = 4;
  localparam int unsigned IDX_W            = 10;
  localparam int unsigned ROT_W            = 2;
  localparam int unsigned PIECE_W          = 3;
  localparam int unsigned LFSR_W           = 8;
  localparam int unsigned STATE_W          = 3;
  localparam logic [7:0]  LFSR_SEED_DFLT   = 8'hA5;
  localparam int unsigned FIT_TIMEOUT_DFLT = 15;

  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_SPAWN     = 3'd1;
  localparam logic [STATE_W-1:0] ST_SPAWN_CHK = 3'd2;
  localparam logic [STATE_W-1:0] ST_ACTIVE    = 3'd3;
  localparam logic [STATE_W-1:0] ST_ROT_CHK   = 3'd4;
  localparam logic [STATE_W-1:0] ST_OVER      = 3'd5;

  // Fold a raw 3-bit draw into 0..n-1 by a single subtraction.
  function automatic logic [PIECE_W-1:0] fold_draw(input logic [PIECE_W-1:0] v,
                                                   input int unsigned n);
    return (32'(v) >= n) ? PIECE_W'(32'(v) - n) : v;
  endfunction

  // Candidate rotation: +1 for clockwise, -1 (mod 4) for counter-clockwise.
  function automatic logic [ROT_W-1:0] rot_next(input logic [ROT_W-1:0] rot,
                                                input logic ccw);
    return rot + (ccw ? ROT_W'(3) : ROT_W'(1));
  endfunction

endpackage

// File: rtl/piece_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4) with the piece-index fold.
module piece_lfsr
  import piece_ctrl_pkg::*;
#(
  parameter int unsigned      NUM_PIECES = NUM_PIECES_DFLT,
  parameter logic [LFSR_W-1:0] SEED      = LFSR_SEED_DFLT
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PIECE_W-1:0] idx_o
);

  localparam logic [LFSR_W-1:0] SEED_NZ = (SEED == '0) ? LFSR_W'(1) : SEED;

  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic [PIECE_W-1:0] idx_q, idx_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    idx_d  = fold_draw(lfsr_d[PIECE_W-1:0], NUM_PIECES);
  end

  // idx_q tracks the fold of the current LFSR value, registered one step ahead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED_NZ;
      idx_q  <= fold_draw(SEED_NZ[PIECE_W-1:0], NUM_PIECES);
    end else begin
      lfsr_q <= lfsr_d;
      idx_q  <= idx_d;
    end
  end

  assign idx_o = idx_q;

endmodule

// File: rtl/piece_ctrl.sv
// Owns the falling piece's identity and rotation; runs the fit-check handshake
// with the collision stage on every spawn and rotate.
module piece_ctrl
  import piece_ctrl_pkg::*;
#(
  parameter int unsigned NUM_PIECES  = NUM_PIECES_DFLT,
  parameter logic [7:0]  LFSR_SEED   = LFSR_SEED_DFLT,
  parameter int unsigned FIT_TIMEOUT = FIT_TIMEOUT_DFLT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         spawn_req,
  input  logic         rot_req,
  input  logic         rot_dir,
  input  logic         lock,
  input  logic         fit_valid,
  input  logic         fit_ok,
  output logic [9:0]   block_num,
  output logic [9:0]   rotate_tmp,
  output logic [2:0]   next_num,
  output logic         fit_req,
  output logic         piece_active,
  output logic         rot_done,
  output logic         game_over
);

  localparam int unsigned CNT_W = $clog2(FIT_TIMEOUT + 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [PIECE_W-1:0] blk_q, blk_d;
  logic [PIECE_W-1:0] nxt_q, nxt_d;
  logic [ROT_W-1:0]   rot_q, rot_d;
  logic [ROT_W-1:0]   tmp_q, tmp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fit_req_q, fit_req_d;
  logic               active_q, active_d;
  logic               done_q, done_d;
  logic               over_q, over_d;
  logic [PIECE_W-1:0] draw;
  logic               timeout;

  piece_lfsr #(
    .NUM_PIECES (NUM_PIECES),
    .SEED       (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .idx_o (draw)
  );

  // Fail on the FIT_TIMEOUT-th cycle spent waiting without a result.
  assign timeout = (cnt_q == CNT_W'(FIT_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    blk_d     = blk_q;
    nxt_d     = nxt_q;
    rot_d     = rot_q;
    tmp_d     = tmp_q;
    cnt_d     = cnt_q;
    fit_req_d = fit_req_q;
    active_d  = active_q;
    done_d    = 1'b0;
    over_d    = over_q;
    case (state_q)
      ST_IDLE: begin
        if (spawn_req) state_d = ST_SPAWN;
      end
      ST_SPAWN: begin
        blk_d     = nxt_q;
        nxt_d     = draw;
        rot_d     = '0;
        tmp_d     = '0;
        cnt_d     = '0;
        fit_req_d = 1'b1;
        state_d   = ST_SPAWN_CHK;
      end
      ST_SPAWN_CHK: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (fit_valid || timeout) begin
          fit_req_d = 1'b0;
          if (fit_valid && fit_ok) begin
            active_d = 1'b1;
            state_d  = ST_ACTIVE;
          end else begin
            over_d  = 1'b1;
            state_d = ST_OVER;
          end
        end
      end
      ST_ACTIVE: begin
        if (lock) begin
          active_d = 1'b0;
          state_d  = ST_IDLE;
        end else if (rot_req) begin
          tmp_d     = rot_next(rot_q, rot_dir);
          cnt_d     = '0;
          fit_req_d = 1'b1;
          state_d   = ST_ROT_CHK;
        end
      end
      ST_ROT_CHK: begin
        cnt_d = cnt_q + CNT_W'(1);
        // tmp_q holds the candidate; any outcome but acceptance restores rot_q.
        if (lock) begin
          active_d  = 1'b0;
          fit_req_d = 1'b0;
          tmp_d     = rot_q;
          state_d   = ST_IDLE;
        end else if (fit_valid || timeout) begin
          fit_req_d = 1'b0;
          state_d   = ST_ACTIVE;
          if (fit_valid && fit_ok) begin
            rot_d  = tmp_q;
            done_d = 1'b1;
          end else begin
            tmp_d = rot_q;
          end
        end
      end
      ST_OVER: begin
        state_d = ST_OVER;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_q     <= '0;
      nxt_q     <= '0;
      rot_q     <= '0;
      tmp_q     <= '0;
      cnt_q     <= '0;
      fit_req_q <= 1'b0;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      blk_q     <= blk_d;
      nxt_q     <= nxt_d;
      rot_q     <= rot_d;
      tmp_q     <= tmp_d;
      cnt_q     <= cnt_d;
      fit_req_q <= fit_req_d;
      active_q  <= active_d;
      done_q    <= done_d;
      over_q    <= over_d;
    end
  end

  assign block_num    = IDX_W'(blk_q);
  assign rotate_tmp   = IDX_W'(tmp_q);
  assign next_num     = nxt_q;
  assign fit_req      = fit_req_q;
  assign piece_active = active_q;
  assign rot_done     = done_q;
  assign game_over    = over_q;

endmodule

// File: tb/tb_piece_ctrl.sv
// Scoreboard bench for piece_ctrl: driver pushes expected fit-check edges, monitor pops and compares.
module tb_piece_ctrl;

  localparam int NP = 5;
  localparam int FT = 15;
  localparam logic [7:0] SEED = 8'hA5;

  logic       clk = 1'b0;
  logic       rst;
  logic       spawn_req, rot_req, rot_dir, lock, fit_valid, fit_ok;
  logic [9:0] block_num, rotate_tmp;
  logic [2:0] next_num;
  logic       fit_req, piece_active, rot_done, game_over;

  piece_ctrl #(.NUM_PIECES(NP), .LFSR_SEED(SEED), .FIT_TIMEOUT(FT)) dut (
    .clk(clk), .rst(rst), .spawn_req(spawn_req), .rot_req(rot_req), .rot_dir(rot_dir),
    .lock(lock), .fit_valid(fit_valid), .fit_ok(fit_ok), .block_num(block_num),
    .rotate_tmp(rotate_tmp), .next_num(next_num), .fit_req(fit_req),
    .piece_active(piece_active), .rot_done(rot_done), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference LFSR sequence, extended on demand: entry n is the value after n steps.
  logic [7:0] seq[$];
  function automatic logic [7:0] lfsr_at(input int n);
    logic [7:0] x;
    while (seq.size() <= n) begin
      x = seq[seq.size()-1];
      seq.push_back({x[6:0], ^(x & 8'hB8)});
    end
    return seq[n];
  endfunction

  function automatic int draw_of(input logic [7:0] s);
    int v;
    v = int'(s[2:0]);
    return (v >= NP) ? v - NP : v;
  endfunction

  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    bit rise; int blk; int nxt; int tmp; bit act; bit done; bit over; int width;
  } exp_t;
  exp_t exp_q[$];

  // Monitor: every fit_req edge consumes one expectation.
  bit   prev_req = 1'b0;
  int   hi_cnt   = 0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_req = 1'b0;
      hi_cnt   = 0;
    end else begin
      if (fit_req !== prev_req) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_fit_req_edge: fit_req=%0b with nothing expected at %0t", fit_req, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("edge_kind", 32'(fit_req), 32'(mon_e.rise));
          chk("block_num", 32'(block_num), mon_e.blk);
          chk("next_num", 32'(next_num), mon_e.nxt);
          chk("rotate_tmp", 32'(rotate_tmp), mon_e.tmp);
          chk("piece_active", 32'(piece_active), 32'(mon_e.act));
          chk("game_over", 32'(game_over), 32'(mon_e.over));
          if (!mon_e.rise) begin
            chk("rot_done", 32'(rot_done), 32'(mon_e.done));
            chk("fit_req_width", hi_cnt, mon_e.width);
          end
        end
      end else begin
        chk("rot_done_quiet", 32'(rot_done), 0);
      end
      if (fit_req === 1'b1) hi_cnt = prev_req ? hi_cnt + 1 : 1;
      prev_req = (fit_req === 1'b1);
    end
  end

  int m_blk, m_nxt, m_rot;
  bit m_act, m_over;
  bit seen[8];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_rise();
    int n = 0;
    while (fit_req !== 1'b1 && n < 6) begin
      tick();
      n++;
    end
    chk("fit_req_rise", 32'(fit_req), 1);
  endtask

  // mode 0: fit_valid after k cycles, 1: let it time out, 2: lock after k cycles
  task automatic resolve(input exp_t f, input int mode, input int k, input bit ok);
    int n = 0;
    f.rise = 1'b0;
    if (mode == 1) begin
      f.width = FT;
      exp_q.push_back(f);
      while (fit_req === 1'b1 && n < FT + 4) begin
        tick();
        n++;
      end
      chk("fit_req_timeout_fall", 32'(fit_req), 0);
    end else begin
      f.width = k + 1;
      exp_q.push_back(f);
      repeat (k) tick();
      if (mode == 0) begin
        fit_valid = 1'b1;
        fit_ok    = ok;
      end else begin
        lock      = 1'b1;
        fit_valid = 1'($urandom_range(0, 1));
        fit_ok    = 1'($urandom_range(0, 1));
      end
      tick();
      fit_valid = 1'b0;
      lock      = 1'b0;
      fit_ok    = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_block_num", 32'(block_num), 0);
    chk("rst_rotate_tmp", 32'(rotate_tmp), 0);
    chk("rst_next_num", 32'(next_num), 0);
    chk("rst_fit_req", 32'(fit_req), 0);
    chk("rst_piece_active", 32'(piece_active), 0);
    chk("rst_rot_done", 32'(rot_done), 0);
    chk("rst_game_over", 32'(game_over), 0);
    tick();
    tick();
    rst = 1'b0;
    m_blk = 0; m_nxt = 0; m_rot = 0; m_act = 0; m_over = 0;
  endtask

  task automatic do_spawn(input int mode, input int k, input bit ok);
    exp_t r;
    int   d;
    bit   good;
    d = draw_of(lfsr_at(cyc + 1));
    r = '{rise:1'b1, blk:m_nxt, nxt:d, tmp:0, act:1'b0, done:1'b0, over:1'b0, width:0};
    exp_q.push_back(r);
    spawn_req = 1'b1;
    tick();
    spawn_req = 1'b0;
    wait_rise();
    good   = (mode == 0) && ok;
    r.act  = good;
    r.over = !good;
    resolve(r, mode, k, ok);
    m_blk = m_nxt; m_nxt = d; m_rot = 0;
    m_act = good; m_over = !good;
  endtask

  task automatic do_rot(input bit dir, input int mode, input int k, input bit ok);
    exp_t r;
    int   cand;
    bit   commit;
    cand = dir ? (m_rot + 3) % 4 : (m_rot + 1) % 4;
    r = '{rise:1'b1, blk:m_blk, nxt:m_nxt, tmp:cand, act:1'b1, done:1'b0, over:1'b0, width:0};
    exp_q.push_back(r);
    rot_req = 1'b1;
    rot_dir = dir;
    tick();
    rot_req = 1'b0;
    rot_dir = 1'($urandom_range(0, 1));
    wait_rise();
    commit = (mode == 0) && ok;
    r.tmp  = commit ? cand : m_rot;
    r.done = commit;
    r.act  = (mode != 2);
    resolve(r, mode, k, ok);
    if (commit) m_rot = cand;
    if (mode == 2) m_act = 1'b0;
  endtask

  task automatic do_lock(input bit with_rot);
    lock    = 1'b1;
    rot_req = with_rot;
    rot_dir = 1'($urandom_range(0, 1));
    tick();
    lock    = 1'b0;
    rot_req = 1'b0;
    chk("lock_release", 32'(piece_active), 0);
    m_act = 1'b0;
  endtask

  // Inputs that the current state must ignore.
  task automatic noise(input int n);
    repeat (n) begin
      fit_valid = 1'($urandom_range(0, 1));
      fit_ok    = 1'($urandom_range(0, 1));
      if (!m_act) begin
        rot_req = 1'($urandom_range(0, 1));
        lock    = 1'($urandom_range(0, 1));
      end
      if (m_over || m_act) spawn_req = 1'($urandom_range(0, 1));
      tick();
      fit_valid = 1'b0; rot_req = 1'b0; lock = 1'b0; spawn_req = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    rst = 1'b1;
    spawn_req = 0; rot_req = 0; rot_dir = 0; lock = 0; fit_valid = 0; fit_ok = 0;
    seq.push_back(SEED);
    tick();
    do_reset();

    do_spawn(0, 0, 1'b1);
    do_rot(1'b1, 0, 2, 1'b1);
    do_rot(1'b0, 0, 0, 1'b1);
    do_rot(1'b0, 0, 3, 1'b0);
    noise(3);
    do_rot(1'b1, 1, 0, 1'b0);
    do_rot(1'b0, 2, 1, 1'b1);
    noise(4);

    do_spawn(0, 1, 1'b1);
    do_lock(1'b1);
    noise(5);
    do_spawn(0, 0, 1'b0);
    noise(20);
    chk("over_sticky", 32'(game_over), 1);
    chk("over_no_fit_req", 32'(fit_req), 0);
    chk("over_inactive", 32'(piece_active), 0);
    do_reset();

    do_spawn(1, 0, 1'b0);
    chk("spawn_timeout_over", 32'(game_over), 1);
    do_reset();

    // Reset while a spawn check waits: the pending result is lost.
    exp_q.push_back('{rise:1'b1, blk:0, nxt:draw_of(lfsr_at(cyc + 1)), tmp:0,
                      act:1'b0, done:1'b0, over:1'b0, width:0});
    spawn_req = 1'b1;
    tick();
    spawn_req = 1'b0;
    wait_rise();
    fit_valid = 1'b1;
    fit_ok    = 1'b1;
    do_reset();
    fit_valid = 1'b0;
    tick();
    chk("mid_rst_inactive", 32'(piece_active), 0);

    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 19));
      if (m_over) begin
        do_reset();
      end else if (!m_act) begin
        if (r < 16)      do_spawn(0, int'($urandom_range(0, 6)), 1'b1);
        else if (r < 17) do_spawn(0, int'($urandom_range(0, 6)), 1'b0);
        else if (r < 18) do_spawn(1, 0, 1'b0);
        else             noise(int'($urandom_range(1, 4)));
      end else begin
        if (r < 12)      do_rot(1'($urandom_range(0, 1)), 0, int'($urandom_range(0, 14)), 1'($urandom_range(0, 1)));
        else if (r < 13) do_rot(1'($urandom_range(0, 1)), 1, 0, 1'b0);
        else if (r < 15) do_rot(1'($urandom_range(0, 1)), 2, int'($urandom_range(0, 14)), 1'b1);
        else if (r < 17) do_lock(1'($urandom_range(0, 1)));
        else             noise(int'($urandom_range(1, 4)));
      end
    end

    do_reset();
    for (int i = 0; i < 10000; i++) begin
      do_spawn(0, 0, 1'b1);
      chk("block_num_range", 32'(block_num < 10'd5), 1);
      seen[block_num[2:0]] = 1'b1;
      do_lock(1'b0);
    end
    for (int p = 0; p < NP; p++) chk("piece_seen", 32'(seen[p]), 1);
    tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
